// File: rtl/sram_ms_pkg.sv
// Shared analog levels and sense-FSM state encoding for the SRAM mixed-signal blocks.
package sram_ms_pkg;

  localparam real VDD = 1.5;
  localparam real VSS = 0.0;
  localparam real VTH = 0.8;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_LATCH  = 2'd2,
    ST_DONE   = 2'd3
  } sense_state_t;

endpackage

// File: rtl/sense_amp_col.sv
// One sense-amp column: bitline compare, latched digital/analog result and optional margin flag.
// Margin checking is built only when SENSE_AMP_MARGIN_CHK_EN is defined.
module sense_amp_col
  import sram_ms_pkg::*;
#(
  parameter real VMARGIN = 0.1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_latch_en,
  input  real  i_bl,
  input  real  i_blb,
  output real  o_preout,
  output logic o_dout,
  output logic o_margin_err
);

  logic w_gt;
  logic r_dout;
  real  r_preout;

  // Equal bitlines resolve to 0 / VSS.
  assign w_gt = (i_bl > i_blb);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout   <= 1'b0;
      r_preout <= VSS;
    end else if (i_latch_en) begin
      r_dout   <= w_gt;
      r_preout <= w_gt ? VDD : VSS;
    end
  end

  assign o_dout   = r_dout;
  assign o_preout = r_preout;

`ifdef SENSE_AMP_MARGIN_CHK_EN
  real  w_diff;
  logic w_small;
  logic r_margin_err;

  assign w_diff  = i_bl - i_blb;
  assign w_small = (w_diff < VMARGIN) && (w_diff > -VMARGIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_margin_err <= 1'b0;
    end else if (i_latch_en) begin
      r_margin_err <= w_small;
    end
  end

  assign o_margin_err = r_margin_err;
`else
  assign o_margin_err = 1'b0;
`endif

endmodule

// File: rtl/sense_amp_array.sv
// NUM_COL-wide sense-amp array with settle/latch sequencing FSM.
// Optional per-column margin check enabled by SENSE_AMP_MARGIN_CHK_EN.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | waiting for sae_req; outputs hold last latched result
// ST_SETTLE | bitline differential developing, down-counter running
// ST_LATCH  | columns latch on the edge that leaves this state
// ST_DONE   | dout_vld strobe for one cycle, requests ignored
module sense_amp_array
  import sram_ms_pkg::*;
#(
  parameter int  NUM_COL    = 8,
  parameter int  SETTLE_CYC = 3,
  parameter real VMARGIN    = 0.1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  real                bl_rd   [NUM_COL],
  input  real                blb_rd  [NUM_COL],
  input  logic               sae_req,
  output logic               busy,
  output real                preout  [NUM_COL],
  output logic [NUM_COL-1:0] dout,
  output logic               dout_vld,
  output logic [NUM_COL-1:0] margin_err
);

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);

  sense_state_t     r_state;
  sense_state_t     w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_latch_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (sae_req) begin
          w_state_nxt = ST_SETTLE;
          w_cnt_nxt   = SETTLE_LOAD;
        end
      end
      ST_SETTLE: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_LATCH;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      ST_LATCH: w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy       = 1'b0;
    dout_vld   = 1'b0;
    w_latch_en = 1'b0;
    case (r_state)
      ST_SETTLE: busy = 1'b1;
      ST_LATCH: begin
        busy       = 1'b1;
        w_latch_en = 1'b1;
      end
      ST_DONE:  dout_vld = 1'b1;
      default:  ;
    endcase
  end

  for (genvar gi = 0; gi < NUM_COL; gi++) begin : g_col
    sense_amp_col #(
      .VMARGIN (VMARGIN)
    ) u_col (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_latch_en   (w_latch_en),
      .i_bl         (bl_rd[gi]),
      .i_blb        (blb_rd[gi]),
      .o_preout     (preout[gi]),
      .o_dout       (dout[gi]),
      .o_margin_err (margin_err[gi])
    );
  end

endmodule
